// File: rtl/ibm_src_arb.sv
// Packet-atomic round-robin arbiter sharing the ibm packet input between PORT and CPU sources.
// Grants only with enough free buffer IDs, then forwards one whole packet with 1-cycle latency.
module ibm_src_arb #(
    parameter logic [4:0] MIN_FREE_BUF = 5'd2,
    parameter logic [7:0] HEAD_TIMEOUT = 8'd64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_arb_port_req,
    output logic         out_arb_port_gnt,
    input  logic [133:0] in_arb_port_data,
    input  logic         in_arb_port_data_wr,
    input  logic         in_arb_port_valid,
    input  logic         in_arb_port_valid_wr,
    input  logic [23:0]  in_arb_port_md,
    input  logic         in_arb_port_md_wr,
    input  logic         in_arb_cpu_req,
    output logic         out_arb_cpu_gnt,
    input  logic [133:0] in_arb_cpu_data,
    input  logic         in_arb_cpu_data_wr,
    input  logic         in_arb_cpu_valid,
    input  logic         in_arb_cpu_valid_wr,
    input  logic [23:0]  in_arb_cpu_md,
    input  logic         in_arb_cpu_md_wr,
    input  logic [4:0]   in_arb_bufm_ID,
    output logic [133:0] out_arb_data,
    output logic         out_arb_data_wr,
    output logic         out_arb_valid,
    output logic         out_arb_valid_wr,
    output logic [23:0]  out_arb_md,
    output logic         out_arb_md_wr,
    output logic         out_arb_busy,
    output logic         out_arb_timeout
);

    typedef enum logic [1:0] {IDLE, WAIT_HEAD, XFER} state_t;
    typedef enum logic {SRC_PORT, SRC_CPU} src_t;

    state_t       state;
    src_t         owner;
    src_t         last_served;
    src_t         winner;
    logic [7:0]   timer;

    logic [133:0] sel_data;
    logic         sel_data_wr;
    logic         sel_valid;
    logic         sel_valid_wr;
    logic [23:0]  sel_md;
    logic         sel_md_wr;

    always_comb begin
        if (owner == SRC_CPU) begin
            sel_data     = in_arb_cpu_data;
            sel_data_wr  = in_arb_cpu_data_wr;
            sel_valid    = in_arb_cpu_valid;
            sel_valid_wr = in_arb_cpu_valid_wr;
            sel_md       = in_arb_cpu_md;
            sel_md_wr    = in_arb_cpu_md_wr;
        end else begin
            sel_data     = in_arb_port_data;
            sel_data_wr  = in_arb_port_data_wr;
            sel_valid    = in_arb_port_valid;
            sel_valid_wr = in_arb_port_valid_wr;
            sel_md       = in_arb_port_md;
            sel_md_wr    = in_arb_port_md_wr;
        end
    end

    // On a tie the source that was not served last wins.
    always_comb begin
        winner = SRC_PORT;
        if (in_arb_port_req && in_arb_cpu_req)
            winner = (last_served == SRC_CPU) ? SRC_PORT : SRC_CPU;
        else if (in_arb_cpu_req)
            winner = SRC_CPU;
    end

    assign out_arb_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            owner            <= SRC_PORT;
            last_served      <= SRC_CPU;
            timer            <= '0;
            out_arb_port_gnt <= 1'b0;
            out_arb_cpu_gnt  <= 1'b0;
            out_arb_data     <= '0;
            out_arb_data_wr  <= 1'b0;
            out_arb_valid    <= 1'b0;
            out_arb_valid_wr <= 1'b0;
            out_arb_md       <= '0;
            out_arb_md_wr    <= 1'b0;
            out_arb_timeout  <= 1'b0;
        end else begin
            out_arb_port_gnt <= 1'b0;
            out_arb_cpu_gnt  <= 1'b0;
            out_arb_data     <= '0;
            out_arb_data_wr  <= 1'b0;
            out_arb_valid    <= 1'b0;
            out_arb_valid_wr <= 1'b0;
            out_arb_md_wr    <= 1'b0;
            out_arb_timeout  <= 1'b0;

            case (state)
                IDLE: begin
                    if ((in_arb_port_req || in_arb_cpu_req) && (in_arb_bufm_ID >= MIN_FREE_BUF)) begin
                        owner            <= winner;
                        last_served      <= winner;
                        timer            <= '0;
                        state            <= WAIT_HEAD;
                        out_arb_port_gnt <= (winner == SRC_PORT);
                        out_arb_cpu_gnt  <= (winner == SRC_CPU);
                    end
                end
                WAIT_HEAD: begin
                    if (sel_data_wr && (sel_data[133:132] == 2'b01)) begin
                        out_arb_data    <= sel_data;
                        out_arb_data_wr <= 1'b1;
                        state           <= XFER;
                    end else if (timer == 8'(HEAD_TIMEOUT - 8'd1)) begin
                        out_arb_timeout <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                XFER: begin
                    if (sel_data_wr) begin
                        out_arb_data    <= sel_data;
                        out_arb_data_wr <= 1'b1;
                    end
                    if (sel_valid_wr) begin
                        out_arb_valid    <= sel_valid;
                        out_arb_valid_wr <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if ((state != IDLE) && sel_md_wr) begin
                out_arb_md    <= sel_md;
                out_arb_md_wr <= 1'b1;
            end
        end
    end

endmodule
